// File: rtl/tq_row_gather16_if.sv
// Row-gather bus: 4-lane beat input side and 16-sample row output side.
// The master drives beats and consumes rows; the gather stage is the slave.
interface tq_row_gather16_if #(
   parameter int WIDTH = 16,
   parameter int LANES = 4
);
   logic                   i_valid;
   logic                   i_ready;
   logic                   i_start;
   logic                   i_enable;
   logic                   i_inverse;
   logic [LANES*WIDTH-1:0] i_data;
   logic                   o_valid;
   logic                   o_ready;
   logic [16*WIDTH-1:0]    o_data;
   logic                   o_enable;
   logic                   o_inverse;
   logic                   o_err;

   modport master (
      output i_valid, i_start, i_enable, i_inverse, i_data, o_ready,
      input  i_ready, o_valid, o_data, o_enable, o_inverse, o_err
   );

   modport slave (
      input  i_valid, i_start, i_enable, i_inverse, i_data, o_ready,
      output i_ready, o_valid, o_data, o_enable, o_inverse, o_err
   );
endinterface

// File: rtl/tq_row_gather16.sv
// Gathers 4 beats of 4 samples into a 16-sample row with sideband.
// Ping-pong banks let one row fill while the previous row waits downstream.
module tq_row_gather16 #(
   parameter int WIDTH = 16,
   parameter int LANES = 4
) (
   input  logic              clk,
   input  logic              rst,
   tq_row_gather16_if.slave  bus
);
   localparam int SLOTS = 16;

   typedef logic [WIDTH-1:0] sample_t;

   sample_t    r_bank [2][SLOTS];
   logic [1:0] r_enable;
   logic [1:0] r_inverse;
   logic [1:0] r_full;
   logic       r_wr_sel;
   logic       r_rd_sel;
   logic [1:0] r_cnt;
   logic       r_err;

   logic w_ready;
   logic w_accept;
   logic w_pop;

   // Ready looks only at registered flags, so it never depends on o_ready.
   assign w_ready  = !r_full[r_wr_sel];
   assign w_accept = bus.i_valid & w_ready;
   assign w_pop    = r_full[r_rd_sel] & bus.o_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the banks are a small register array, not a RAM, so they are
         // cleared here to make o_data read zero straight out of reset.
         for (int b = 0; b < 2; b++) begin
            for (int n = 0; n < SLOTS; n++) begin
               r_bank[b][n] <= '0;
            end
         end
         r_enable  <= '0;
         r_inverse <= '0;
         r_full    <= '0;
         r_wr_sel  <= 1'b0;
         r_rd_sel  <= 1'b0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (w_accept) begin
            if (bus.i_start) begin
               // A start mid-row abandons the partial row and flags the error.
               for (int j = 0; j < LANES; j++) begin
                  r_bank[r_wr_sel][4'(j)] <= bus.i_data[j*WIDTH +: WIDTH];
               end
               r_enable[r_wr_sel]  <= bus.i_enable;
               r_inverse[r_wr_sel] <= bus.i_inverse;
               r_cnt               <= 2'd1;
               r_err               <= (r_cnt != 2'd0);
            end else if (r_cnt == 2'd0) begin
               r_err <= 1'b1;
            end else begin
               for (int j = 0; j < LANES; j++) begin
                  r_bank[r_wr_sel][{r_cnt, 2'(j)}] <= bus.i_data[j*WIDTH +: WIDTH];
               end
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  r_full[r_wr_sel] <= 1'b1;
                  r_wr_sel         <= ~r_wr_sel;
               end
            end
         end
         // Fill and free always target different banks, so both updates land.
         if (w_pop) begin
            r_full[r_rd_sel] <= 1'b0;
            r_rd_sel         <= ~r_rd_sel;
         end
      end
   end

   always_comb begin
      // NOTE: default first so no path through the block leaves a latch.
      bus.o_data = '0;
      for (int n = 0; n < SLOTS; n++) begin
         bus.o_data[n*WIDTH +: WIDTH] = r_bank[r_rd_sel][n];
      end
   end

   assign bus.i_ready   = w_ready;
   assign bus.o_valid   = r_full[r_rd_sel];
   assign bus.o_enable  = r_enable[r_rd_sel];
   assign bus.o_inverse = r_inverse[r_rd_sel];
   assign bus.o_err     = r_err;

endmodule

// File: tb/tb_tq_row_gather16.sv
// Bench for tq_row_gather16: a directed vector table, hand-written corner sequences,
// and a random stream compared against a queue-based row model.
module tb_tq_row_gather16;
   localparam int WIDTH = 16;
   localparam int LANES = 4;

   typedef logic [LANES*WIDTH-1:0] beat_t;
   typedef logic [16*WIDTH-1:0]    row_t;

   typedef struct {
      row_t data;
      logic en;
      logic inv;
   } mrow_t;

   typedef struct {
      logic  v, s, e, inv, rdy;
      beat_t d;
      logic  x_ready, x_valid, x_err, x_en, x_inv;
      row_t  x_data;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   tq_row_gather16_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   tq_row_gather16 #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: rows waiting downstream (at most two) plus the row being collected.
   mrow_t q[$];
   row_t  part;
   logic  p_en, p_inv, m_err;
   int    p_cnt;

   function automatic beat_t seq_beat(int base);
      beat_t b;
      for (int j = 0; j < LANES; j++) b[j*WIDTH +: WIDTH] = 16'(base + j);
      return b;
   endfunction

   function automatic row_t seq_row(int base);
      row_t r;
      for (int n = 0; n < 16; n++) r[n*WIDTH +: WIDTH] = 16'(base + n);
      return r;
   endfunction

   function automatic beat_t row_beat(row_t r, int k);
      return r[k*LANES*WIDTH +: LANES*WIDTH];
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input row_t act, input row_t exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      part  = '0;
      p_en  = 1'b0;
      p_inv = 1'b0;
      p_cnt = 0;
      m_err = 1'b0;
   endtask

   task automatic model_edge(input logic v, s, e, inv, input beat_t d, input logic rdy);
      logic  ready;
      logic  pop;
      mrow_t done;
      ready = (q.size() < 2);
      pop   = (q.size() > 0) && rdy;
      m_err = 1'b0;
      if (v && ready) begin
         if (s) begin
            m_err           = (p_cnt != 0);
            part[63:0]      = d;
            p_en            = e;
            p_inv           = inv;
            p_cnt           = 1;
         end else if (p_cnt == 0) begin
            m_err = 1'b1;
         end else begin
            part[p_cnt*64 +: 64] = d;
            if (p_cnt == 3) begin
               done.data = part;
               done.en   = p_en;
               done.inv  = p_inv;
               q.push_back(done);
               p_cnt = 0;
            end else begin
               p_cnt++;
            end
         end
      end
      if (pop) void'(q.pop_front());
   endtask

   task automatic drive(input logic v, s, e, inv, input beat_t d, input logic rdy);
      bus.i_valid   = v;
      bus.i_start   = s;
      bus.i_enable  = e;
      bus.i_inverse = inv;
      bus.i_data    = d;
      bus.o_ready   = rdy;
   endtask

   // One cycle checked against the model: drive at negedge, compare, then advance the model at posedge.
   task automatic step(input string tag, input logic v, s, e, inv, input beat_t d, input logic rdy);
      @(negedge clk);
      drive(v, s, e, inv, d, rdy);
      #1;
      check1({tag, ".i_ready"}, bus.i_ready, q.size() < 2);
      check1({tag, ".o_valid"}, bus.o_valid, q.size() > 0);
      check1({tag, ".o_err"},   bus.o_err,   m_err);
      if (q.size() > 0) begin
         checkw({tag, ".o_data"},    bus.o_data,    q[0].data);
         check1({tag, ".o_enable"},  bus.o_enable,  q[0].en);
         check1({tag, ".o_inverse"}, bus.o_inverse, q[0].inv);
      end
      @(posedge clk);
      model_edge(v, s, e, inv, d, rdy);
   endtask

   task automatic idle(input string tag, input logic rdy, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, rdy);
   endtask

   task automatic send_row(input string tag, input row_t r, input logic e, inv, rdy);
      for (int k = 0; k < 4; k++) begin
         int   tries;
         logic acc;
         tries = 0;
         do begin
            acc = (q.size() < 2);
            step(tag, 1'b1, k == 0, e, inv, row_beat(r, k), rdy);
            tries++;
         end while (!acc && tries < 40);
         if (!acc) check1({tag, ".stall_timeout"}, 1'b0, 1'b1);
      end
   endtask

   task automatic apply_vec(input vec_t t, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      drive(t.v, t.s, t.e, t.inv, t.d, t.rdy);
      #1;
      check1({tag, ".i_ready"}, bus.i_ready, t.x_ready);
      check1({tag, ".o_valid"}, bus.o_valid, t.x_valid);
      check1({tag, ".o_err"},   bus.o_err,   t.x_err);
      if (t.x_valid) begin
         checkw({tag, ".o_data"},    bus.o_data,    t.x_data);
         check1({tag, ".o_enable"},  bus.o_enable,  t.x_en);
         check1({tag, ".o_inverse"}, bus.o_inverse, t.x_inv);
      end
      @(posedge clk);
      model_edge(t.v, t.s, t.e, t.inv, t.d, t.rdy);
   endtask

   function automatic vec_t mk(input logic v, s, e, inv, input beat_t d, input logic rdy,
                               input logic xr, xv, xe, xen, xinv, input row_t xd);
      vec_t t;
      t.v = v; t.s = s; t.e = e; t.inv = inv; t.d = d; t.rdy = rdy;
      t.x_ready = xr; t.x_valid = xv; t.x_err = xe; t.x_en = xen; t.x_inv = xinv;
      t.x_data = xd;
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[16];

      tbl[0]  = mk(1, 1, 1, 0, seq_beat(0),   1, 1, 0, 0, 0, 0, '0);
      tbl[1]  = mk(1, 0, 0, 0, seq_beat(4),   1, 1, 0, 0, 0, 0, '0);
      tbl[2]  = mk(1, 0, 0, 0, seq_beat(8),   1, 1, 0, 0, 0, 0, '0);
      tbl[3]  = mk(1, 0, 0, 0, seq_beat(12),  1, 1, 0, 0, 0, 0, '0);
      tbl[4]  = mk(0, 0, 0, 0, '0,            1, 1, 1, 0, 1, 0, seq_row(0));
      tbl[5]  = mk(0, 0, 0, 0, '0,            1, 1, 0, 0, 0, 0, '0);
      tbl[6]  = mk(1, 0, 0, 1, seq_beat(200), 1, 1, 0, 0, 0, 0, '0);
      tbl[7]  = mk(0, 0, 0, 0, '0,            1, 1, 0, 1, 0, 0, '0);
      tbl[8]  = mk(0, 0, 0, 0, '0,            1, 1, 0, 0, 0, 0, '0);
      tbl[9]  = mk(1, 1, 0, 1, seq_beat(16),  0, 1, 0, 0, 0, 0, '0);
      tbl[10] = mk(1, 0, 0, 0, seq_beat(20),  0, 1, 0, 0, 0, 0, '0);
      tbl[11] = mk(1, 0, 0, 0, seq_beat(24),  0, 1, 0, 0, 0, 0, '0);
      tbl[12] = mk(1, 0, 0, 0, seq_beat(28),  0, 1, 0, 0, 0, 0, '0);
      tbl[13] = mk(0, 0, 0, 0, '0,            0, 1, 1, 0, 0, 1, seq_row(16));
      tbl[14] = mk(0, 0, 0, 0, '0,            1, 1, 1, 0, 0, 1, seq_row(16));
      tbl[15] = mk(0, 0, 0, 0, '0,            1, 1, 0, 0, 0, 0, '0);

      rst = 1'b1;
      drive(0, 0, 0, 0, '0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check1("reset.o_valid",   bus.o_valid,   1'b0);
      check1("reset.i_ready",   bus.i_ready,   1'b1);
      check1("reset.o_err",     bus.o_err,     1'b0);
      check1("reset.o_enable",  bus.o_enable,  1'b0);
      check1("reset.o_inverse", bus.o_inverse, 1'b0);
      checkw("reset.o_data",    bus.o_data,    '0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) apply_vec(tbl[i], i);

      // Backpressure: two rows buffered, third row's first beat held until space frees.
      send_row("bp.row1", seq_row(1000), 1'b1, 1'b0, 1'b0);
      send_row("bp.row2", seq_row(2000), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      check1("bp.ready_low", bus.i_ready, 1'b0);
      for (int i = 0; i < 3; i++) step("bp.hold", 1'b1, 1'b1, 1'b1, 1'b1, row_beat(seq_row(3000), 0), 1'b0);
      send_row("bp.row3", seq_row(3000), 1'b1, 1'b1, 1'b1);
      idle("bp.drain", 1'b1, 4);

      // Sustained stream including the signed extremes.
      for (int r = 0; r < 8; r++) begin
         row_t rw;
         for (int w = 0; w < 8; w++) rw[w*32 +: 32] = $urandom;
         rw[(r % 16)*WIDTH +: WIDTH]       = 16'h8000;
         rw[((r + 5) % 16)*WIDTH +: WIDTH] = 16'h7FFF;
         send_row("stream", rw, r[0], r[1], 1'b1);
      end
      idle("stream.drain", 1'b1, 3);

      // Restart on beat 2 abandons the partial row.
      step("restart.b0", 1'b1, 1'b1, 1'b1, 1'b1, seq_beat(50), 1'b1);
      step("restart.b1", 1'b1, 1'b0, 1'b1, 1'b1, seq_beat(54), 1'b1);
      send_row("restart.row", seq_row(100), 1'b0, 1'b1, 1'b1);
      idle("restart.drain", 1'b1, 3);

      // Stray beat without start while idle.
      step("stray", 1'b1, 1'b0, 1'b1, 1'b0, seq_beat(77), 1'b1);
      idle("stray.after", 1'b1, 3);

      // Reset during beat 2 of a row.
      step("rst1.b0", 1'b1, 1'b1, 1'b1, 1'b1, seq_beat(300), 1'b1);
      step("rst1.b1", 1'b1, 1'b0, 1'b1, 1'b1, seq_beat(304), 1'b1);
      @(negedge clk);
      drive(1, 0, 1, 1, seq_beat(308), 1);
      rst = 1'b1;
      #1;
      check1("rst1.o_valid", bus.o_valid, 1'b0);
      check1("rst1.i_ready", bus.i_ready, 1'b1);
      checkw("rst1.o_data",  bus.o_data,  '0);
      model_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, '0, 1);
      rst = 1'b0;
      step("rst1.b3", 1'b1, 1'b0, 1'b1, 1'b1, seq_beat(312), 1'b1);
      idle("rst1.after", 1'b1, 3);

      // Reset while a row is presented and held.
      send_row("rst2.row", seq_row(400), 1'b1, 1'b0, 1'b0);
      idle("rst2.wait", 1'b0, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, '0, 0);
      rst = 1'b1;
      #1;
      check1("rst2.o_valid",  bus.o_valid,  1'b0);
      check1("rst2.i_ready",  bus.i_ready,  1'b1);
      check1("rst2.o_enable", bus.o_enable, 1'b0);
      checkw("rst2.o_data",   bus.o_data,   '0);
      model_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, '0, 1);
      rst = 1'b0;
      idle("rst2.after", 1'b1, 4);
      send_row("rst2.new", seq_row(500), 1'b0, 1'b0, 1'b1);
      idle("rst2.drain", 1'b1, 2);

      // Random stream against the model.
      for (int i = 0; i < 400; i++) begin
         beat_t d;
         d = {$urandom, $urandom};
         step("rand", ($urandom % 4) != 0, ($urandom % 4) == 0, 1'($urandom), 1'($urandom), d,
              ($urandom % 3) != 0);
      end
      idle("rand.drain", 1'b1, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
